// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: receive-side checker for a VGA sync stream.
// Measures HS/VS timing against the configured mode and tracks lock
// (SEARCH/ACQUIRE/LOCKED). While locked it recovers the pixel column and row.
// Optional build macro VGA_MON_CRC_EN adds a per-frame CRC-16-CCITT of the
// visible RGB pixels (frame_crc / crc_valid).
module vga_timing_monitor #(
   parameter int H_TOTAL     = 1056,
   parameter int H_SYNC      = 128,
   parameter int H_BACK      = 88,
   parameter int H_VISIBLE   = 800,
   parameter int V_TOTAL     = 628,
   parameter int V_SYNC      = 4,
   parameter int V_BACK      = 23,
   parameter int V_VISIBLE   = 600,
   parameter int SYNC_POL    = 1,
   parameter int LOCK_FRAMES = 2
) (
   input  logic        clock_40mhz,
   input  logic        reset,
   input  logic        horiz_sync_in,
   input  logic        vert_sync_in,
   input  logic [3:0]  red_in,
   input  logic [3:0]  green_in,
   input  logic [3:0]  blue_in,
   output logic        locked,
   output logic [1:0]  state,
   output logic        h_err,
   output logic        v_err,
   output logic [11:0] h_period,
   output logic [9:0]  v_lines,
   output logic [7:0]  loss_count,
   output logic [15:0] frame_count,
   output logic        video_active,
   output logic [9:0]  pixel_col,
   output logic [9:0]  pixel_row
`ifdef VGA_MON_CRC_EN
   ,
   output logic [15:0] frame_crc,
   output logic        crc_valid
`endif
);

   typedef enum logic [1:0] {
      SEARCH  = 2'b00,
      ACQUIRE = 2'b01,
      LOCKED  = 2'b10
   } mon_state_t;

   localparam logic        ACT_LVL = (SYNC_POL != 0);
   localparam logic [11:0] H_OFF   = 12'(H_SYNC + H_BACK);
   localparam logic [11:0] H_END   = 12'(H_SYNC + H_BACK + H_VISIBLE);
   localparam logic [11:0] H_TMO   = 12'(2 * H_TOTAL);
   localparam logic [9:0]  V_OFF   = 10'(V_SYNC + V_BACK);
   localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BACK + V_VISIBLE);

   mon_state_t  state_q;
   logic        hs_q, vs_q;
   logic [11:0] h_cnt_q, h_cnt_d;
   logic [9:0]  v_cnt_q, v_cnt_d, v_cnt_plus;
   logic [9:0]  vw_cnt_q, vw_cnt_d;
   logic        h_meas_valid_q, v_meas_valid_q;
   logic        frame_bad_q, frame_bad_now;
   logic        h_err_q, v_err_q;
   logic [11:0] h_period_q;
   logic [9:0]  v_lines_q;
   logic [7:0]  good_cnt_q;
   logic [7:0]  loss_q;
   logic [15:0] frame_cnt_q;
   logic        active_q, active_d;
   logic [9:0]  col_q, col_d, row_q, row_d;

   logic hs_cur, vs_cur, hs_lead, hs_trail, vs_lead, vs_trail;
   logic h_err_now, v_per_bad, v_wid_bad, enter_search;

   // Edge detection, counter next-state, error evaluation and pixel recovery
   always_comb begin
      hs_cur    = horiz_sync_in ^ ~ACT_LVL;
      vs_cur    = vert_sync_in ^ ~ACT_LVL;
      hs_lead   = hs_cur & ~hs_q;
      hs_trail  = ~hs_cur & hs_q;
      vs_lead   = vs_cur & ~vs_q;
      vs_trail  = ~vs_cur & vs_q;

      h_cnt_d   = hs_lead ? '0 : ((h_cnt_q == '1) ? h_cnt_q : h_cnt_q + 12'd1);

      // HS edge is folded into the line count before the VS edge is judged
      v_cnt_plus = (hs_lead && (v_cnt_q != '1)) ? v_cnt_q + 10'd1 : v_cnt_q;
      v_cnt_d    = vs_lead ? '0 : v_cnt_plus;

      vw_cnt_d = vw_cnt_q;
      if (vs_lead)
         vw_cnt_d = hs_lead ? 10'd1 : 10'd0;
      else if (vs_cur && hs_lead && (vw_cnt_q != '1))
         vw_cnt_d = vw_cnt_q + 10'd1;

      h_err_now = h_meas_valid_q &&
                  ((hs_lead  && (({1'b0, h_cnt_q} + 13'd1) != 13'(H_TOTAL))) ||
                   (hs_trail && (({1'b0, h_cnt_q} + 13'd1) != 13'(H_SYNC)))   ||
                   (!hs_lead && (h_cnt_q == H_TMO)));
      v_per_bad = vs_lead  && v_meas_valid_q && (v_cnt_plus != 10'(V_TOTAL));
      v_wid_bad = vs_trail && v_meas_valid_q && (vw_cnt_q != 10'(V_SYNC));

      frame_bad_now = frame_bad_q | h_err_now | v_per_bad;
      enter_search  = (state_q == LOCKED) && (h_err_now || (vs_lead && frame_bad_now));

      // Recovery uses next-state counters so outputs line up with h_cnt/v_cnt
      active_d = (state_q == LOCKED) && !enter_search &&
                 (h_cnt_d >= H_OFF) && (h_cnt_d < H_END) &&
                 (v_cnt_d >= V_OFF) && (v_cnt_d < V_END);
      col_d    = active_d ? 10'(h_cnt_d - H_OFF) : '0;
      row_d    = active_d ? (v_cnt_d - V_OFF) : '0;
   end

   // Sync sampling, line/frame counters, measurements and sticky errors
   always_ff @(posedge clock_40mhz) begin
      if (reset) begin
         hs_q           <= 1'b0;
         vs_q           <= 1'b0;
         h_cnt_q        <= '0;
         v_cnt_q        <= '0;
         vw_cnt_q       <= '0;
         h_meas_valid_q <= 1'b0;
         v_meas_valid_q <= 1'b0;
         frame_bad_q    <= 1'b0;
         h_err_q        <= 1'b0;
         v_err_q        <= 1'b0;
         h_period_q     <= '0;
         v_lines_q      <= '0;
      end else begin
         hs_q     <= hs_cur;
         vs_q     <= vs_cur;
         h_cnt_q  <= h_cnt_d;
         v_cnt_q  <= v_cnt_d;
         vw_cnt_q <= vw_cnt_d;
         if (enter_search)
            h_meas_valid_q <= 1'b0;
         else if (hs_lead)
            h_meas_valid_q <= 1'b1;
         if (enter_search)
            v_meas_valid_q <= 1'b0;
         else if (vs_lead)
            v_meas_valid_q <= 1'b1;
         if (hs_lead && h_meas_valid_q)
            h_period_q <= (h_cnt_q == '1) ? h_cnt_q : h_cnt_q + 12'd1;
         if (vs_lead && v_meas_valid_q)
            v_lines_q <= v_cnt_plus;
         h_err_q     <= h_err_q | h_err_now;
         v_err_q     <= v_err_q | v_per_bad | v_wid_bad;
         frame_bad_q <= vs_lead ? 1'b0 : (frame_bad_q | h_err_now | v_wid_bad);
      end
   end

   // Lock state machine with loss and frame counters
   always_ff @(posedge clock_40mhz) begin
      if (reset) begin
         state_q     <= SEARCH;
         good_cnt_q  <= '0;
         loss_q      <= '0;
         frame_cnt_q <= '0;
      end else begin
         unique case (state_q)
            SEARCH: begin
               if (vs_lead) begin
                  state_q    <= ACQUIRE;
                  good_cnt_q <= '0;
               end
            end
            ACQUIRE: begin
               if (vs_lead) begin
                  if (frame_bad_now)
                     good_cnt_q <= '0;
                  else if ((good_cnt_q + 8'd1) >= 8'(LOCK_FRAMES)) begin
                     state_q    <= LOCKED;
                     good_cnt_q <= '0;
                  end else
                     good_cnt_q <= good_cnt_q + 8'd1;
               end
            end
            LOCKED: begin
               if (vs_lead)
                  frame_cnt_q <= frame_cnt_q + 16'd1;
               if (enter_search) begin
                  state_q <= SEARCH;
                  if (loss_q != '1)
                     loss_q <= loss_q + 8'd1;
               end
            end
            default: state_q <= SEARCH;
         endcase
      end
   end

   // Registered pixel position recovery
   always_ff @(posedge clock_40mhz) begin
      if (reset) begin
         active_q <= 1'b0;
         col_q    <= '0;
         row_q    <= '0;
      end else begin
         active_q <= active_d;
         col_q    <= col_d;
         row_q    <= row_d;
      end
   end

`ifdef VGA_MON_CRC_EN
   logic [15:0] crc_q, frame_crc_q;
   logic        crc_valid_q;

   function automatic logic [15:0] crc12_step(input logic [15:0] crc, input logic [11:0] d);
      logic [15:0] c;
      logic        fb;
      c = crc;
      for (int unsigned i = 0; i < 12; i++) begin
         fb = c[15] ^ d[11 - i];
         c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return c;
   endfunction

   // Per-frame CRC over visible pixels, published at each locked VS edge
   always_ff @(posedge clock_40mhz) begin
      if (reset) begin
         crc_q       <= 16'hFFFF;
         frame_crc_q <= '0;
         crc_valid_q <= 1'b0;
      end else begin
         crc_valid_q <= 1'b0;
         if (vs_lead) begin
            if (state_q == LOCKED) begin
               frame_crc_q <= crc_q;
               crc_valid_q <= 1'b1;
            end
            crc_q <= 16'hFFFF;
         end else if (active_d) begin
            crc_q <= crc12_step(crc_q, {red_in, green_in, blue_in});
         end
      end
   end

   assign frame_crc = frame_crc_q;
   assign crc_valid = crc_valid_q;
`else
   logic unused_rgb;
   assign unused_rgb = ^{red_in, green_in, blue_in};
`endif

   assign locked       = (state_q == LOCKED);
   assign state        = state_q;
   assign h_err        = h_err_q;
   assign v_err        = v_err_q;
   assign h_period     = h_period_q;
   assign v_lines      = v_lines_q;
   assign loss_count   = loss_q;
   assign frame_count  = frame_cnt_q;
   assign video_active = active_q;
   assign pixel_col    = col_q;
   assign pixel_row    = row_q;

endmodule
